// File: rtl/tank_pkg.sv
// Shared tank types and constants: coordinate/angle widths, angle range,
// scheduler state encoding and the committed pose record.
package tank_pkg;

    localparam int COORD_W = 10;
    localparam int ANG_W   = 7;
    localparam int ANG_MAX = 90;

    typedef enum logic [3:0] {
        IDLE,
        SEL,
        ROT_PROP,
        ROT_WAIT,
        ROT_CHK,
        MOV_PROP,
        MOV_WAIT,
        MOV_CHK,
        NEXT
    } sched_state_t;

    typedef struct packed {
        logic [COORD_W-1:0] x;
        logic [COORD_W-1:0] y;
        logic [ANG_W-1:0]   angle;
    } tank_pose_t;

    // One angle step, wrapping at both ends of 0..ANG_MAX-1; cw=1 steps up.
    function automatic logic [ANG_W-1:0] ang_step(input logic [ANG_W-1:0] a, input logic cw);
        if (cw)
            return (a == ANG_W'(ANG_MAX - 1)) ? '0 : a + ANG_W'(1);
        else
            return (a == '0) ? ANG_W'(ANG_MAX - 1) : a - ANG_W'(1);
    endfunction

endpackage

// File: rtl/tank_dir_lut.sv
// Angle -> unit step. One angle unit is 4 degrees; dx = round(2*cos),
// dy = round(2*sin), so each component is a signed value in -2..2.
module tank_dir_lut
    import tank_pkg::*;
(
    input  logic [ANG_W-1:0] angle,
    output logic signed [2:0] dx,
    output logic signed [2:0] dy
);

    logic [ANG_W-1:0] m45;
    logic [ANG_W-1:0] dc;
    logic [ANG_W:0]   a2;
    logic [ANG_W:0]   ds2;
    logic [2:0]       cmag;
    logic [2:0]       smag;

    // dc: distance (units) to nearest 0/180 deg; ds2: distance (half units)
    // to nearest 90/270 deg. Thresholds are where 2*cos crosses 1.5 and 0.5.
    always_comb begin
        m45 = (angle >= 7'd45) ? angle - 7'd45 : angle;
        dc  = (m45 <= 7'd22) ? m45 : 7'd45 - m45;
        a2  = {angle, 1'b0};
        if (a2 <= 8'd90)
            ds2 = (a2 >= 8'd45) ? a2 - 8'd45 : 8'd45 - a2;
        else
            ds2 = (a2 >= 8'd135) ? a2 - 8'd135 : 8'd135 - a2;
        cmag = (dc <= 7'd10) ? 3'd2 : (dc <= 7'd18) ? 3'd1 : 3'd0;
        smag = (ds2 <= 8'd20) ? 3'd2 : (ds2 <= 8'd37) ? 3'd1 : 3'd0;
        dx   = (angle >= 7'd23 && angle <= 7'd67) ? 3'd0 - cmag : cmag;
        dy   = (angle > 7'd45) ? 3'd0 - smag : smag;
    end

endmodule

// File: rtl/tank_move_sched.sv
// Per-frame rotate/move scheduler sharing one collision checker across tanks.
// Optional frame-overrun counter: define TANK_MOVE_SCHED_OVERRUN_EN.
module tank_move_sched
    import tank_pkg::*;
#(
    parameter int                 NUM_TANKS = 2,
    parameter int                 WAIT_CYC  = 2,
    parameter logic [COORD_W-1:0] SPAWN_X0  = 10'd80,
    parameter logic [COORD_W-1:0] SPAWN_Y0  = 10'd80,
    parameter logic [ANG_W-1:0]   SPAWN_A0  = 7'd0,
    parameter logic [COORD_W-1:0] SPAWN_X1  = 10'd560,
    parameter logic [COORD_W-1:0] SPAWN_Y1  = 10'd400,
    parameter logic [ANG_W-1:0]   SPAWN_A1  = 7'd45
) (
    input  logic                           Clk,
    input  logic                           Reset_n,
    input  logic                           frame_tick,
    input  logic [NUM_TANKS-1:0]           fwd,
    input  logic [NUM_TANKS-1:0]           rev,
    input  logic [NUM_TANKS-1:0]           left,
    input  logic [NUM_TANKS-1:0]           right,
    input  logic                           front_col,
    input  logic                           back_col,
    output logic [COORD_W-1:0]             col_x,
    output logic [COORD_W-1:0]             col_y,
    output logic [ANG_W-1:0]               col_angle,
    output logic [NUM_TANKS*COORD_W-1:0]   tank_x,
    output logic [NUM_TANKS*COORD_W-1:0]   tank_y,
    output logic [NUM_TANKS*ANG_W-1:0]     tank_angle,
    output logic                           busy,
    output logic                           done,
    output logic [7:0]                     overrun_cnt,
    output logic [3:0]                     dbg_state
);

    localparam int IDX_W = (NUM_TANKS > 1) ? $clog2(NUM_TANKS) : 1;
    localparam int WC_W  = $clog2(WAIT_CYC + 1);

    sched_state_t         state;
    logic [IDX_W-1:0]     idx;
    logic [WC_W-1:0]      wait_cnt;
    logic [NUM_TANKS-1:0] fwd_s, rev_s, left_s, right_s;
    tank_pose_t           pose [NUM_TANKS];

    tank_pose_t           cur;
    logic                 rot_req, mov_req, last_tank, advance;
    logic signed [2:0]    dx, dy;
    logic [COORD_W-1:0]   step_x, step_y;

    function automatic tank_pose_t spawn_pose(input int i);
        tank_pose_t p;
        if (i == 1) begin
            p.x = SPAWN_X1; p.y = SPAWN_Y1; p.angle = SPAWN_A1;
        end else begin
            p.x = SPAWN_X0; p.y = SPAWN_Y0; p.angle = SPAWN_A0;
        end
        return p;
    endfunction

    // A checked tank hands over to the next one straight from its last CHK
    // state; only request-free tanks pass through NEXT.
    always_comb begin
        cur       = pose[idx];
        rot_req   = left_s[idx] ^ right_s[idx];
        mov_req   = fwd_s[idx] ^ rev_s[idx];
        last_tank = (idx == IDX_W'(NUM_TANKS - 1));
        step_x    = {{(COORD_W-3){dx[2]}}, dx};
        step_y    = {{(COORD_W-3){dy[2]}}, dy};
        advance   = (state == NEXT) || (state == MOV_CHK) || (state == ROT_CHK && !mov_req);
    end

    tank_dir_lut u_dir (
        .angle (cur.angle),
        .dx    (dx),
        .dy    (dy)
    );

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state     <= IDLE;
            idx       <= '0;
            wait_cnt  <= '0;
            fwd_s     <= '0;
            rev_s     <= '0;
            left_s    <= '0;
            right_s   <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            col_x     <= SPAWN_X0;
            col_y     <= SPAWN_Y0;
            col_angle <= SPAWN_A0;
            for (int i = 0; i < NUM_TANKS; i++) pose[i] <= spawn_pose(i);
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    col_x     <= pose[0].x;
                    col_y     <= pose[0].y;
                    col_angle <= pose[0].angle;
                    if (frame_tick) begin
                        fwd_s   <= fwd;
                        rev_s   <= rev;
                        left_s  <= left;
                        right_s <= right;
                        idx     <= '0;
                        busy    <= 1'b1;
                        state   <= SEL;
                    end
                end
                SEL: begin
                    if (rot_req)      state <= ROT_PROP;
                    else if (mov_req) state <= MOV_PROP;
                    else              state <= NEXT;
                end
                ROT_PROP: begin
                    col_x     <= cur.x;
                    col_y     <= cur.y;
                    col_angle <= ang_step(cur.angle, right_s[idx]);
                    wait_cnt  <= WC_W'(WAIT_CYC - 1);
                    state     <= ROT_WAIT;
                end
                ROT_WAIT: begin
                    if (wait_cnt == '0) state <= ROT_CHK;
                    else                wait_cnt <= wait_cnt - WC_W'(1);
                end
                ROT_CHK: begin
                    if (!front_col && !back_col) pose[idx].angle <= col_angle;
                    if (mov_req) state <= MOV_PROP;
                end
                MOV_PROP: begin
                    col_x     <= fwd_s[idx] ? cur.x + step_x : cur.x - step_x;
                    col_y     <= fwd_s[idx] ? cur.y + step_y : cur.y - step_y;
                    col_angle <= cur.angle;
                    wait_cnt  <= WC_W'(WAIT_CYC - 1);
                    state     <= MOV_WAIT;
                end
                MOV_WAIT: begin
                    if (wait_cnt == '0) state <= MOV_CHK;
                    else                wait_cnt <= wait_cnt - WC_W'(1);
                end
                MOV_CHK: begin
                    if (fwd_s[idx] ? !front_col : !back_col) begin
                        pose[idx].x <= col_x;
                        pose[idx].y <= col_y;
                    end
                end
                NEXT: ;
                default: state <= IDLE;
            endcase

            if (advance) begin
                if (last_tank) begin
                    state     <= IDLE;
                    busy      <= 1'b0;
                    done      <= 1'b1;
                    col_x     <= pose[0].x;
                    col_y     <= pose[0].y;
                    col_angle <= pose[0].angle;
                end else begin
                    idx   <= idx + IDX_W'(1);
                    state <= SEL;
                end
            end
        end
    end

    for (genvar i = 0; i < NUM_TANKS; i++) begin : g_out
        assign tank_x[i*COORD_W +: COORD_W]   = pose[i].x;
        assign tank_y[i*COORD_W +: COORD_W]   = pose[i].y;
        assign tank_angle[i*ANG_W +: ANG_W]   = pose[i].angle;
    end

    assign dbg_state = state;

`ifdef TANK_MOVE_SCHED_OVERRUN_EN
    logic [7:0] ovr_q;

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n)
            ovr_q <= 8'd0;
        else if (frame_tick && busy && ovr_q != 8'hFF)
            ovr_q <= ovr_q + 8'd1;
    end

    assign overrun_cnt = ovr_q;
`else
    assign overrun_cnt = 8'd0;
`endif

endmodule

// File: tb/tb_tank_move_sched.sv
// Bench for tank_move_sched: vector table plus random frames, checked against
// a trig-based pose model through an expected-pose queue.
module tb_tank_move_sched;
    import tank_pkg::*;

    localparam int  NT = 2;
    localparam int  WC = 2;
    localparam int  PW = 54;
    localparam real PI = 3.14159265358979;

    // clock / reset
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic        frame_tick = 1'b0;
    logic [1:0]  fwd = '0, rev = '0, left = '0, right = '0;
    logic        front_col = 1'b0, back_col = 1'b0;
    logic [9:0]  col_x, col_y;
    logic [6:0]  col_angle;
    logic [19:0] tank_x, tank_y;
    logic [13:0] tank_angle;
    logic        busy, done;
    logic [7:0]  overrun_cnt;
    logic [3:0]  dbg_state;

    tank_move_sched #(.NUM_TANKS(NT), .WAIT_CYC(WC)) dut (
        .Clk(clk), .Reset_n(rst_n), .frame_tick(frame_tick),
        .fwd(fwd), .rev(rev), .left(left), .right(right),
        .front_col(front_col), .back_col(back_col),
        .col_x(col_x), .col_y(col_y), .col_angle(col_angle),
        .tank_x(tank_x), .tank_y(tank_y), .tank_angle(tank_angle),
        .busy(busy), .done(done), .overrun_cnt(overrun_cnt), .dbg_state(dbg_state)
    );

    // scoreboard
    int n_cmp = 0;
    int n_err = 0;
    logic [PW-1:0] exp_q[$];
    int mx[NT], my[NT], ma[NT];

    typedef struct {
        logic [1:0] fwd, rev, left, right;
        logic       front, back;
        int         lat;
    } vec_t;
    vec_t vecs[10];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic int dir_dx(input int a);
        return int'(2.0 * $cos(real'(a) * 4.0 * PI / 180.0));
    endfunction

    function automatic int dir_dy(input int a);
        return int'(2.0 * $sin(real'(a) * 4.0 * PI / 180.0));
    endfunction

    function automatic logic [PW-1:0] model_pack();
        return {10'(mx[0]), 10'(my[0]), 7'(ma[0]), 10'(mx[1]), 10'(my[1]), 7'(ma[1])};
    endfunction

    function automatic logic [PW-1:0] dut_pack();
        return {tank_x[9:0], tank_y[9:0], tank_angle[6:0], tank_x[19:10], tank_y[19:10], tank_angle[13:7]};
    endfunction

    task automatic model_reset();
        mx[0] = 80;  my[0] = 80;  ma[0] = 0;
        mx[1] = 560; my[1] = 400; ma[1] = 45;
    endtask

    task automatic model_frame(input logic [1:0] f, input logic [1:0] r, input logic [1:0] l,
                               input logic [1:0] rt, input logic fc, input logic bc);
        for (int t = 0; t < NT; t++) begin
            int cand, dx, dy;
            if (l[t] ^ rt[t]) begin
                cand = rt[t] ? (ma[t] + 1) % 90 : (ma[t] + 89) % 90;
                if (!fc && !bc) ma[t] = cand;
            end
            if (f[t] ^ r[t]) begin
                dx = dir_dx(ma[t]);
                dy = dir_dy(ma[t]);
                if (f[t] ? !fc : !bc) begin
                    if (f[t]) begin
                        mx[t] = (mx[t] + dx) & 1023;
                        my[t] = (my[t] + dy) & 1023;
                    end else begin
                        mx[t] = (mx[t] - dx) & 1023;
                        my[t] = (my[t] - dy) & 1023;
                    end
                end
            end
        end
    endtask

    function automatic int lat_of(input logic [1:0] f, input logic [1:0] r,
                                  input logic [1:0] l, input logic [1:0] rt);
        int s = 0;
        for (int t = 0; t < NT; t++) begin
            logic ro, mo;
            ro = l[t] ^ rt[t];
            mo = f[t] ^ r[t];
            if (ro && mo)      s += 5 + 2 * WC;
            else if (ro || mo) s += 3 + WC;
            else               s += 2;
        end
        return s;
    endfunction

    // driver: one frame, keys scrambled after the tick edge, optional re-tick
    task automatic run_frame(input logic [1:0] f, input logic [1:0] r, input logic [1:0] l,
                             input logic [1:0] rt, input logic fc, input logic bc,
                             input int exp_lat, input int retick_at, input string tag);
        int cyc;
        logic [PW-1:0] exp;
        @(negedge clk);
        fwd = f; rev = r; left = l; right = rt;
        front_col = fc; back_col = bc;
        frame_tick = 1'b1;
        model_frame(f, r, l, rt, fc, bc);
        exp_q.push_back(model_pack());
        @(negedge clk);
        frame_tick = 1'b0;
        fwd = 2'($urandom_range(0, 3)); rev = 2'($urandom_range(0, 3));
        left = 2'($urandom_range(0, 3)); right = 2'($urandom_range(0, 3));
        check($sformatf("%s busy", tag), 64'(busy), 64'd1);
        cyc = 0;
        while (!done && cyc < 300) begin
            @(negedge clk);
            cyc++;
            frame_tick = (cyc == retick_at);
        end
        frame_tick = 1'b0;
        check($sformatf("%s latency", tag), 64'(cyc), 64'(exp_lat));
        exp = exp_q.pop_front();
        check($sformatf("%s pose", tag), 64'(dut_pack()), 64'(exp));
        check($sformatf("%s busy_end", tag), 64'(busy), 64'd0);
        @(negedge clk);
        check($sformatf("%s done_width", tag), 64'(done), 64'd0);
        check($sformatf("%s idle_col", tag), 64'({col_x, col_y, col_angle}),
              64'({10'(mx[0]), 10'(my[0]), 7'(ma[0])}));
    endtask

    initial begin
        int cyc;
        int exp_ovr;
        logic [1:0] f, r, l, rt;
        logic fc, bc;

        vecs[0] = '{2'b00, 2'b00, 2'b00, 2'b01, 1'b0, 1'b0, 7};
        vecs[1] = '{2'b00, 2'b00, 2'b01, 2'b00, 1'b0, 1'b0, 7};
        vecs[2] = '{2'b00, 2'b00, 2'b01, 2'b00, 1'b0, 1'b0, 7};
        vecs[3] = '{2'b00, 2'b00, 2'b00, 2'b01, 1'b0, 1'b0, 7};
        vecs[4] = '{2'b10, 2'b00, 2'b00, 2'b00, 1'b1, 1'b0, 7};
        vecs[5] = '{2'b00, 2'b10, 2'b00, 2'b00, 1'b1, 1'b0, 7};
        vecs[6] = '{2'b11, 2'b11, 2'b11, 2'b11, 1'b0, 1'b0, 4};
        vecs[7] = '{2'b01, 2'b10, 2'b10, 2'b01, 1'b0, 1'b0, 18};
        vecs[8] = '{2'b01, 2'b00, 2'b00, 2'b00, 1'b0, 1'b1, 7};
        vecs[9] = '{2'b00, 2'b01, 2'b01, 2'b00, 1'b1, 1'b0, 11};

        model_reset();
        repeat (3) @(negedge clk);
        check("rst pose", 64'(dut_pack()), 64'(model_pack()));
        check("rst busy", 64'(busy), 64'd0);
        check("rst done", 64'(done), 64'd0);
        check("rst overrun", 64'(overrun_cnt), 64'd0);
        check("rst col", 64'({col_x, col_y, col_angle}), 64'({10'd80, 10'd80, 7'd0}));
        check("rst state", 64'(dbg_state), 64'(IDLE));
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        for (int i = 0; i < 10; i++)
            run_frame(vecs[i].fwd, vecs[i].rev, vecs[i].left, vecs[i].right,
                      vecs[i].front, vecs[i].back, vecs[i].lat, -1, $sformatf("vec%0d", i));

        for (int i = 0; i < 6; i++) begin
            f  = 2'($urandom_range(0, 3)); r  = 2'($urandom_range(0, 3));
            l  = 2'($urandom_range(0, 3)); rt = 2'($urandom_range(0, 3));
            fc = 1'($urandom_range(0, 1)); bc = 1'($urandom_range(0, 1));
            run_frame(f, r, l, rt, fc, bc, lat_of(f, r, l, rt), -1, $sformatf("rnd%0d", i));
        end

        // frame_tick while busy: ignored by the sequence, counted when enabled
        run_frame(2'b10, 2'b00, 2'b00, 2'b01, 1'b0, 1'b0,
                  lat_of(2'b10, 2'b00, 2'b00, 2'b01), 3, "retick");
`ifdef TANK_MOVE_SCHED_OVERRUN_EN
        exp_ovr = 1;
`else
        exp_ovr = 0;
`endif
        check("overrun_cnt", 64'(overrun_cnt), 64'(exp_ovr));

        // reset asserted while a move candidate is in flight
        @(negedge clk);
        fwd = 2'b01; rev = 2'b00; left = 2'b00; right = 2'b00;
        front_col = 1'b0; back_col = 1'b0;
        frame_tick = 1'b1;
        @(negedge clk);
        frame_tick = 1'b0;
        cyc = 0;
        while (dbg_state != 4'(MOV_WAIT) && cyc < 50) begin
            @(negedge clk);
            cyc++;
        end
        check("reach MOV_WAIT", 64'(dbg_state), 64'(MOV_WAIT));
        rst_n = 1'b0;
        #1;
        model_reset();
        check("midrst pose", 64'(dut_pack()), 64'(model_pack()));
        check("midrst busy", 64'(busy), 64'd0);
        check("midrst state", 64'(dbg_state), 64'(IDLE));
        check("midrst overrun", 64'(overrun_cnt), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (6) @(negedge clk);
        check("postrst pose", 64'(dut_pack()), 64'(model_pack()));
        check("postrst col", 64'({col_x, col_y, col_angle}), 64'({10'd80, 10'd80, 7'd0}));
        check("postrst done", 64'(done), 64'd0);
        check("queue drained", 64'(exp_q.size()), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
